gmp_ds_gen_multi: RTL

//  Parametrised successor of the single-slot stuff/data generator: decides data (1) vs stuff (0)
//  for LANES consecutive payload slots per clock. Rule: slot j (1..pm) is data iff (j*cm) mod pm < cm.

---
 rtl/gmp_ds_gen_multi_if.sv | 39 +++
 rtl/gmp_ds_gen_multi.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gmp_ds_gen_multi_if.sv
// ---------------------------------------------------------------------------
// gmp_ds_gen_multi_if
// Bus between the frame-header parser / payload mapper and the multi-lane
// stuff/data generator.
//   master : drives pm, cm, valid_in, sof; receives the decision beat.
//   slave  : the generator; receives pm, cm, valid_in, sof and drives
//            ds, ds_mask, valid_out, sof_out, eof_out, data_cnt and the
//            err_input / err_sof_early / err_sof_late pulses.
// ---------------------------------------------------------------------------
interface gmp_ds_gen_multi_if #(
    parameter int MPT_W = 8,
    parameter int LANES = 4
);
    logic [MPT_W-1:0] pm;
    logic [MPT_W-1:0] cm;
    logic             valid_in;
    logic             sof;
    logic [LANES-1:0] ds;
    logic [LANES-1:0] ds_mask;
    logic             valid_out;
    logic             sof_out;
    logic             eof_out;
    logic [MPT_W-1:0] data_cnt;
    logic             err_input;
    logic             err_sof_early;
    logic             err_sof_late;

    modport master (
        output pm, cm, valid_in, sof,
        input  ds, ds_mask, valid_out, sof_out, eof_out, data_cnt,
               err_input, err_sof_early, err_sof_late
    );

    modport slave (
        input  pm, cm, valid_in, sof,
        output ds, ds_mask, valid_out, sof_out, eof_out, data_cnt,
               err_input, err_sof_early, err_sof_late
    );
endinterface

// File: rtl/gmp_ds_gen_multi.sv
// ---------------------------------------------------------------------------
// gmp_ds_gen_multi
// Decides data (1) or stuff (0) for LANES consecutive payload slots per valid
// beat. Slot j (1..pm) carries data iff (j*cm) mod pm < cm. The running
// remainder (acc) replaces the multiply: each slot adds cm and subtracts pm
// at most once, which is exact because cm <= pm is enforced at SOF load.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : gmp_ds_gen_multi_if.slave
//                pm/cm        frame parameters, sampled only on SOF load
//                valid_in/sof beat qualifier / start of frame
//                ds/ds_mask   per-lane decision and valid-slot mask
//                valid_out    ds/ds_mask valid (1-cycle latency)
//                sof_out      frame loaded; eof_out beat contains slot pm
//                data_cnt     data slots emitted in the current frame
//                err_*        one-cycle error pulses
// ---------------------------------------------------------------------------
module gmp_ds_gen_multi #(
    parameter int MPT_W = 8,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gmp_ds_gen_multi_if.slave  bus
);
    // Slot arithmetic needs headroom beyond MPT_W so slot+LANES never wraps.
    localparam int SW = MPT_W + $clog2(LANES + 1) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [MPT_W-1:0] pm_q;
    logic [MPT_W-1:0] cm_q;
    logic [MPT_W-1:0] acc_q;   // (slot_q * cm_q) mod pm_q
    logic [MPT_W-1:0] slot_q;  // slots already emitted in this frame

    // Per-beat combinational decision for all lanes.
    logic [LANES-1:0] ds_c;
    logic [LANES-1:0] mask_c;
    logic [MPT_W-1:0] acc_c;
    logic [MPT_W-1:0] ones_c;
    logic             eof_c;
    logic             sof_legal;
    logic [MPT_W:0]   rem;
    logic [MPT_W:0]   sum;
    logic [SW-1:0]    slot_j;

    assign sof_legal = (bus.pm != '0) && (bus.cm <= bus.pm);

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rem    = {1'b0, acc_q};
        sum    = '0;
        slot_j = '0;
        ds_c   = '0;
        mask_c = '0;
        ones_c = '0;
        for (int k = 0; k < LANES; k++) begin
            slot_j = SW'(slot_q) + SW'(k + 1);
            sum    = rem + {1'b0, cm_q};
            if (sum >= {1'b0, pm_q}) begin
                sum = sum - {1'b0, pm_q};
            end
            // Lanes past slot pm are masked and leave the remainder untouched.
            if (slot_j <= SW'(pm_q)) begin
                mask_c[k] = 1'b1;
                ds_c[k]   = (sum < {1'b0, cm_q});
                rem       = sum;
                ones_c    = ones_c + MPT_W'(ds_c[k]);
            end
        end
        acc_c = rem[MPT_W-1:0];
        eof_c = (SW'(slot_q) + SW'(LANES)) >= SW'(pm_q);
    end

    // NOTE: the asynchronous reset clears every register, including the
    // latched pm/cm, so a frame interrupted by reset can never resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            pm_q              <= '0;
            cm_q              <= '0;
            acc_q             <= '0;
            slot_q            <= '0;
            bus.ds            <= '0;
            bus.ds_mask       <= '0;
            bus.valid_out     <= 1'b0;
            bus.sof_out       <= 1'b0;
            bus.eof_out       <= 1'b0;
            bus.data_cnt      <= '0;
            bus.err_input     <= 1'b0;
            bus.err_sof_early <= 1'b0;
            bus.err_sof_late  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; defaults below make
            // every pulse output last exactly one cycle.
            bus.ds            <= '0;
            bus.ds_mask       <= '0;
            bus.valid_out     <= 1'b0;
            bus.sof_out       <= 1'b0;
            bus.eof_out       <= 1'b0;
            bus.err_input     <= 1'b0;
            bus.err_sof_early <= 1'b0;
            bus.err_sof_late  <= 1'b0;

            if (bus.valid_in) begin
                if (bus.sof) begin
                    // In RUN slot pm has not been emitted yet (eof returns to IDLE).
                    if (state == RUN) begin
                        bus.err_sof_early <= 1'b1;
                    end
                    if (sof_legal) begin
                        pm_q         <= bus.pm;
                        cm_q         <= bus.cm;
                        acc_q        <= '0;
                        slot_q       <= '0;
                        bus.data_cnt <= '0;
                        bus.sof_out  <= 1'b1;
                        state        <= RUN;
                    end else begin
                        bus.err_input <= 1'b1;
                        state         <= IDLE;
                    end
                end else if (state == IDLE) begin
                    bus.err_sof_late <= 1'b1;
                end else begin
                    bus.ds        <= ds_c;
                    bus.ds_mask   <= mask_c;
                    bus.valid_out <= 1'b1;
                    acc_q         <= acc_c;
                    slot_q        <= slot_q + MPT_W'(LANES);
                    bus.data_cnt  <= bus.data_cnt + ones_c;
                    if (eof_c) begin
                        bus.eof_out <= 1'b1;
                        state       <= IDLE;
                    end
                end
            end
        end
    end
endmodule
